// File: rtl/bit_scanner_pkg.sv
// Shared types for the bit_scanner block: FSM state encoding and width limits.
package bit_scanner_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_EMPTY = 2'd2
    } state_e;

    localparam int unsigned MIN_WIDTH = 32'd2;
    localparam int unsigned MAX_WIDTH = 32'd64;

endpackage : bit_scanner_pkg

// File: rtl/bit_scanner_prio_enc.sv
// Combinational find-first-set over a vector, in ascending or descending index order.
module prio_enc #(
    parameter  int WIDTH     = 8,
    parameter  bit MSB_FIRST = 1'b0,
    localparam int PW        = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] vec_i,
    output logic [PW-1:0]    pos_o,
    output logic             any_o
);

    // The later loop iteration wins, so the sweep direction selects the preferred end.
    always_comb begin
        pos_o = '0;
        any_o = |vec_i;
        if (MSB_FIRST) begin
            for (int i = 0; i < WIDTH; i++) begin
                pos_o = vec_i[i] ? PW'(i) : pos_o;
            end
        end else begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                pos_o = vec_i[i] ? PW'(i) : pos_o;
            end
        end
    end

endmodule : prio_enc

// File: rtl/bit_scanner.sv
// Accepts a vector and emits one beat per set bit in scan order.
// Optional feature: BIT_SCANNER_EMPTY_FLAG_EN reports all-zero vectors as a single beat.
module bit_scanner
    import bit_scanner_pkg::*;
#(
    parameter  int WIDTH     = 8,
    parameter  bit MSB_FIRST = 1'b0,
    localparam int PW        = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             areset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PW-1:0]    out_pos,
    output logic             out_last
`ifdef BIT_SCANNER_EMPTY_FLAG_EN
    ,
    output logic             out_empty
`endif
);

    state_e             state_q;
    logic [WIDTH-1:0]   rem_q;
    logic [WIDTH-1:0]   rem_d;
    logic [PW-1:0]      enc_pos_s;
    logic               enc_any_s;
    logic               last_s;

    prio_enc #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_prio_enc (
        .vec_i (rem_q),
        .pos_o (enc_pos_s),
        .any_o (enc_any_s)
    );

    // Next remaining-bits value after the current beat is consumed, and the single-bit test.
    always_comb begin
        rem_d  = rem_q & ~({{(WIDTH-1){1'b0}}, 1'b1} << enc_pos_s);
        last_s = enc_any_s && ((rem_q & (rem_q - {{(WIDTH-1){1'b0}}, 1'b1})) == '0);
    end

    // Scan FSM: accept in IDLE, walk rem in SCAN, single empty beat in EMPTY.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        rem_q <= in_vec;
                        if (|in_vec) begin
                            state_q <= ST_SCAN;
                        end else begin
`ifdef BIT_SCANNER_EMPTY_FLAG_EN
                            state_q <= ST_EMPTY;
`else
                            state_q <= ST_IDLE;
`endif
                        end
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_SCAN: begin
                    if (out_ready) begin
                        rem_q <= rem_d;
                        state_q <= last_s ? ST_IDLE : ST_SCAN;
                    end else begin
                        state_q <= ST_SCAN;
                    end
                end
                ST_EMPTY: begin
                    rem_q   <= '0;
                    state_q <= out_ready ? ST_IDLE : ST_EMPTY;
                end
                default: begin
                    rem_q   <= '0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Outputs decode only registered state; position and last are forced low when idle.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_pos   = '0;
        out_last  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
            end
            ST_SCAN: begin
                out_valid = 1'b1;
                out_pos   = enc_pos_s;
                out_last  = last_s;
            end
            ST_EMPTY: begin
                out_valid = 1'b1;
                out_last  = 1'b1;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

`ifdef BIT_SCANNER_EMPTY_FLAG_EN
    assign out_empty = (state_q == ST_EMPTY);
`endif

endmodule : bit_scanner

// File: tb/tb_bit_scanner.sv
// Directed bench for bit_scanner: LSB/MSB-first 8-bit instances and a 16-bit instance.
module tb_bit_scanner;

    logic clk = 1'b0;
    logic areset_n = 1'b0;

    logic       a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b1, a_out_last;
    logic [7:0] a_in_vec = 8'h00;
    logic [2:0] a_out_pos;
    logic       b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b1, b_out_last;
    logic [7:0] b_in_vec = 8'h00;
    logic [2:0] b_out_pos;
    logic        c_in_valid = 1'b0, c_in_ready, c_out_valid, c_out_ready = 1'b1, c_out_last;
    logic [15:0] c_in_vec = 16'h0000;
    logic [3:0]  c_out_pos;
`ifdef BIT_SCANNER_EMPTY_FLAG_EN
    logic a_out_empty, b_out_empty, c_out_empty;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bit_scanner #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_a (
        .clk(clk), .areset_n(areset_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_vec(a_in_vec), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_pos(a_out_pos), .out_last(a_out_last)
`ifdef BIT_SCANNER_EMPTY_FLAG_EN
        , .out_empty(a_out_empty)
`endif
    );

    bit_scanner #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_b (
        .clk(clk), .areset_n(areset_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_vec(b_in_vec), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_pos(b_out_pos), .out_last(b_out_last)
`ifdef BIT_SCANNER_EMPTY_FLAG_EN
        , .out_empty(b_out_empty)
`endif
    );

    bit_scanner #(.WIDTH(16), .MSB_FIRST(1'b0)) dut_c (
        .clk(clk), .areset_n(areset_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_vec(c_in_vec), .out_valid(c_out_valid), .out_ready(c_out_ready),
        .out_pos(c_out_pos), .out_last(c_out_last)
`ifdef BIT_SCANNER_EMPTY_FLAG_EN
        , .out_empty(c_out_empty)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    int exp_a[4] = '{0, 2, 5, 7};
    int exp_b[4] = '{7, 5, 2, 0};

    initial begin
        // Reset state
        @(negedge clk);
        chk("rst_in_ready", 32'(a_in_ready), 32'd1);
        chk("rst_out_valid", 32'(a_out_valid), 32'd0);
        chk("rst_out_pos", 32'(a_out_pos), 32'd0);
        chk("rst_out_last", 32'(a_out_last), 32'd0);
        areset_n = 1'b1;

        // Single bit 8'h01
        @(negedge clk);
        a_in_valid = 1'b1; a_in_vec = 8'h01; a_out_ready = 1'b1;
        chk("h01_ready_accept", 32'(a_in_ready), 32'd1);
        @(negedge clk);
        a_in_valid = 1'b0;
        chk("h01_valid", 32'(a_out_valid), 32'd1);
        chk("h01_pos", 32'(a_out_pos), 32'd0);
        chk("h01_last", 32'(a_out_last), 32'd1);
        chk("h01_ready_busy", 32'(a_in_ready), 32'd0);
        @(negedge clk);
        chk("h01_done_valid", 32'(a_out_valid), 32'd0);
        chk("h01_done_ready", 32'(a_in_ready), 32'd1);
        chk("h01_done_last", 32'(a_out_last), 32'd0);

        // 8'hA5 on both scan orders; dut_a also sees ignored input mid-scan
        a_in_valid = 1'b1; a_in_vec = 8'hA5;
        b_in_valid = 1'b1; b_in_vec = 8'hA5;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            b_in_valid = 1'b0;
            if (i == 0) begin
                a_in_vec = 8'hFF;
            end else if (i == 3) begin
                a_in_valid = 1'b0;
            end
            chk($sformatf("a5_lsb_valid%0d", i), 32'(a_out_valid), 32'd1);
            chk($sformatf("a5_lsb_pos%0d", i), 32'(a_out_pos), 32'(exp_a[i]));
            chk($sformatf("a5_lsb_last%0d", i), 32'(a_out_last), (i == 3) ? 32'd1 : 32'd0);
            chk($sformatf("a5_msb_pos%0d", i), 32'(b_out_pos), 32'(exp_b[i]));
            chk($sformatf("a5_msb_last%0d", i), 32'(b_out_last), (i == 3) ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        chk("a5_lsb_idle", 32'(a_out_valid), 32'd0);
        chk("a5_msb_idle", 32'(b_out_valid), 32'd0);
        chk("a5_lsb_ready", 32'(a_in_ready), 32'd1);

        // 8'h18 with backpressure
        a_in_valid = 1'b1; a_in_vec = 8'h18; a_out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a_in_valid = 1'b0;
            chk($sformatf("h18_hold_valid%0d", i), 32'(a_out_valid), 32'd1);
            chk($sformatf("h18_hold_pos%0d", i), 32'(a_out_pos), 32'd3);
            chk($sformatf("h18_hold_last%0d", i), 32'(a_out_last), 32'd0);
        end
        @(negedge clk);
        a_out_ready = 1'b1;
        chk("h18_pos_first", 32'(a_out_pos), 32'd3);
        @(negedge clk);
        chk("h18_pos_second", 32'(a_out_pos), 32'd4);
        chk("h18_last_second", 32'(a_out_last), 32'd1);
        @(negedge clk);
        chk("h18_idle", 32'(a_out_valid), 32'd0);

        // All-zero vector
        a_in_valid = 1'b1; a_in_vec = 8'h00;
        @(negedge clk);
        a_in_valid = 1'b0;
`ifdef BIT_SCANNER_EMPTY_FLAG_EN
        chk("zero_valid", 32'(a_out_valid), 32'd1);
        chk("zero_empty", 32'(a_out_empty), 32'd1);
        chk("zero_pos", 32'(a_out_pos), 32'd0);
        chk("zero_last", 32'(a_out_last), 32'd1);
        @(negedge clk);
        chk("zero_after_valid", 32'(a_out_valid), 32'd0);
        chk("zero_after_empty", 32'(a_out_empty), 32'd0);
`else
        chk("zero_valid", 32'(a_out_valid), 32'd0);
        chk("zero_ready", 32'(a_in_ready), 32'd1);
        @(negedge clk);
        chk("zero_after_valid", 32'(a_out_valid), 32'd0);
`endif
        chk("zero_after_ready", 32'(a_in_ready), 32'd1);

        // 8'hFF interrupted by reset after three beats
        a_in_valid = 1'b1; a_in_vec = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a_in_valid = 1'b0;
            chk($sformatf("hff_pos%0d", i), 32'(a_out_pos), 32'(i));
        end
        @(posedge clk);
        #2 areset_n = 1'b0;
        #1;
        chk("hff_rst_valid", 32'(a_out_valid), 32'd0);
        chk("hff_rst_ready", 32'(a_in_ready), 32'd1);
        chk("hff_rst_pos", 32'(a_out_pos), 32'd0);
        @(negedge clk);
        areset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("hff_post_valid%0d", i), 32'(a_out_valid), 32'd0);
            chk($sformatf("hff_post_ready%0d", i), 32'(a_in_ready), 32'd1);
        end

        // 16-bit top bit
        c_in_valid = 1'b1; c_in_vec = 16'h8000;
        @(negedge clk);
        c_in_valid = 1'b0;
        chk("w16_valid", 32'(c_out_valid), 32'd1);
        chk("w16_pos", 32'(c_out_pos), 32'd15);
        chk("w16_last", 32'(c_out_last), 32'd1);
        @(negedge clk);
        chk("w16_idle", 32'(c_out_valid), 32'd0);
        chk("w16_ready", 32'(c_in_ready), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_bit_scanner
